writeback_handler: RTL and testbench
====================================

WRITEBACK_HANDLER -- requirements
Module: writeback_handler

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of PC, ALU and memory data.
REQ-002 SHALL have parameter MAX_WAIT, default 16: maximum memory-wait cycles before a load is aborted.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: a MEM-stage instruction is presented this cycle.
REQ-006 SHALL have port out_sel, input, 2: writeback-source selector from MEM (00 PC, 01 PC for call, 10 ALU, 11 load data).
REQ-007 SHALL have ports pc, alu_out and mem_rdata, each input, DATA_W: the candidate writeback sources.
REQ-008 SHALL have port mem_ready, input, 1: mem_rdata is valid this cycle.
REQ-009 SHALL have ports rd (input, 5: destination register) and rf_le (input, 1: instruction writes a register).
REQ-010 SHALL have port flush, input, 1: kill the in-flight instruction.
REQ-011 SHALL have ports rf_we (output, 1), rf_waddr (output, 5) and rf_wdata (output, DATA_W): the register-file write port.
REQ-012 SHALL have port stall_req, output, 1: freeze upstream pipeline stages.
REQ-013 SHALL have ports fwd_valid (output, 1), fwd_rd (output, 5) and fwd_data (output, DATA_W): the WB forwarding source.
REQ-014 SHALL have port mem_err, output, 1: one-cycle pulse when a load times out.

Function
REQ-015 SHALL implement FSM states IDLE and WAIT_MEM.
REQ-016 In IDLE, in_valid with out_sel 00, 01 or 10, or out_sel 11 with mem_ready, SHALL register the selected data, rd and rf_le; the write appears on rf_* in the next cycle (latency 1).
REQ-017 In IDLE, in_valid with out_sel 11 and no mem_ready SHALL capture rd and rf_le, clear the wait counter, assert stall_req combinationally that same cycle, and enter WAIT_MEM.
REQ-018 In WAIT_MEM, stall_req SHALL stay 1; the counter SHALL increment each cycle without mem_ready.
REQ-019 In WAIT_MEM, mem_ready SHALL capture mem_rdata, deassert stall_req in that same cycle, write on the next cycle and return to IDLE.
REQ-020 When the counter reaches MAX_WAIT-1 without mem_ready, the block SHALL pulse mem_err for one cycle, perform no write and return to IDLE.
REQ-021 rf_we SHALL equal the registered rf_le AND (rf_waddr != 0); writes to %g0 are suppressed.
REQ-022 rf_we SHALL be a single-cycle pulse per accepted instruction.
REQ-023 fwd_valid, fwd_rd and fwd_data SHALL mirror rf_we, rf_waddr and rf_wdata.
REQ-024 flush SHALL dominate everything: no write next cycle, FSM to IDLE, stall_req 0 that cycle, even when mem_ready is simultaneously high.
REQ-025 in_valid SHALL be ignored while in WAIT_MEM, because upstream is stalled.

Reset
REQ-026 When reset is 1 at a clock edge, the block SHALL set FSM to IDLE, counter 0, and rf_we, rf_waddr, rf_wdata, fwd_* and mem_err to 0.
REQ-027 stall_req SHALL be 0 while reset is asserted.
REQ-028 Reset in WAIT_MEM SHALL abandon the load without writing; a mem_ready arriving after reset is ignored.

Structure
REQ-029 The out_sel encodings (SEL_PC 00, SEL_CALL 01, SEL_ALU 10, SEL_LOAD 11) and the FSM state encoding SHALL live in the shared processor package.
REQ-030 The block SHALL be one module, with the source mux as an inline combinational case and no sub-module.

Verification
REQ-031 The bench SHALL cover: ALU writeback, in_valid=1, sel=10, alu_out=0x1234, rd=5, rf_le=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, one pulse.
REQ-032 The bench SHALL cover: call, sel=01, pc=0x40, rd=15 -> next cycle write r15=0x40.
REQ-033 The bench SHALL cover: load wait, sel=11, mem_ready low for 3 cycles then high with mem_rdata=0xCAFE, rd=8 -> stall_req high for exactly 3 cycles, then write r8=0xCAFE one cycle after mem_ready.
REQ-034 The bench SHALL cover: timeout, MAX_WAIT=4, mem_ready never asserted -> one mem_err pulse, no rf_we, stall_req drops, FSM in IDLE.
REQ-035 The bench SHALL cover: %g0, sel=10, rd=0, rf_le=1 -> rf_we stays 0.
REQ-036 The bench SHALL cover: flush in WAIT_MEM coinciding with mem_ready=1 -> no write, stall_req=0 that cycle, next load accepted normally.

Source files
------------

// File: rtl/writeback_handler_pkg.sv
// writeback_handler_pkg: shared writeback-source selector and FSM encodings
package writeback_handler_pkg;
  typedef enum logic [1:0] {SEL_PC = 2'b00, SEL_CALL = 2'b01, SEL_ALU = 2'b10, SEL_LOAD = 2'b11} sel_e;
  typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_e;
endpackage

// File: rtl/writeback_handler.sv
// writeback_handler: WB stage that selects the writeback source, waits for loads with a timeout,
// and drives the register-file write port and forwarding source.
module writeback_handler
  import writeback_handler_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [1:0]        out_sel,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic [4:0]        rd,
  input  logic              rf_le,
  input  logic              flush,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall_req,
  output logic              fwd_valid,
  output logic [4:0]        fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              mem_err
);
  localparam int CW = MAX_WAIT > 2 ? $clog2(MAX_WAIT) : 1;
  state_e state, state_nxt;
  logic [CW-1:0] cnt;
  logic wb_le, pend_le;
  logic [4:0] pend_rd;
  logic [DATA_W-1:0] src;
  logic load_miss, accept, load_done, timeout;
  always_comb begin
    case (out_sel)
      SEL_PC, SEL_CALL: src = pc;
      SEL_ALU:          src = alu_out;
      default:          src = mem_rdata;
    endcase
  end
  assign load_miss = in_valid && out_sel == SEL_LOAD && !mem_ready;
  assign accept    = state == IDLE && in_valid && !flush && !load_miss;
  assign load_done = state == WAIT_MEM && mem_ready && !flush;
  assign timeout   = state == WAIT_MEM && !mem_ready && !flush && cnt == CW'(MAX_WAIT - 1);
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = flush ? IDLE : state == IDLE ? (load_miss ? WAIT_MEM : IDLE) : (mem_ready || timeout) ? IDLE : WAIT_MEM;
  end
  always_comb begin
    stall_req = !reset && !flush && (state == IDLE ? load_miss : !mem_ready);
  end
  // pending rd/rf_le are sampled every IDLE cycle so they hold the load's values on entry to WAIT_MEM
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      wb_le    <= 1'b0;
      pend_le  <= 1'b0;
      pend_rd  <= '0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      mem_err  <= 1'b0;
    end else begin
      wb_le   <= (accept && rf_le) || (load_done && pend_le);
      mem_err <= timeout;
      if (accept) begin
        rf_waddr <= rd;
        rf_wdata <= src;
      end else if (load_done) begin
        rf_waddr <= pend_rd;
        rf_wdata <= mem_rdata;
      end
      if (state == IDLE) begin
        cnt     <= '0;
        pend_rd <= rd;
        pend_le <= rf_le;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
  assign rf_we     = wb_le && rf_waddr != 5'd0;
  assign fwd_valid = rf_we;
  assign fwd_rd    = rf_waddr;
  assign fwd_data  = rf_wdata;
endmodule

// File: tb/tb_writeback_handler.sv
// tb_writeback_handler: directed scenarios plus randomized instructions checked against a transaction-level model
module tb_writeback_handler;
  localparam int DW = 32;
  localparam int MW = 4;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, mem_ready = 1'b0, rf_le = 1'b0, flush = 1'b0;
  logic [1:0] out_sel = 2'b00;
  logic [DW-1:0] pc = '0, alu_out = '0, mem_rdata = '0;
  logic [4:0] rd = '0;
  logic rf_we, stall_req, fwd_valid, mem_err;
  logic [4:0] rf_waddr, fwd_rd;
  logic [DW-1:0] rf_wdata, fwd_data;
  int n_checks = 0, n_fail = 0;

  writeback_handler #(.DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .out_sel(out_sel), .pc(pc), .alu_out(alu_out),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .rd(rd), .rf_le(rf_le), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .stall_req(stall_req),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; mem_ready = 1'b0; flush = 1'b0; rf_le = 1'b0; out_sel = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_sel = 2'b11; mem_ready = 1'b0; rf_le = 1'b1; rd = 5'd7;
    #1;
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall_req); end
    cyc();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we got %b want 0", rf_we); end
    n_checks++; if (rf_waddr !== 5'd0 || rf_wdata !== '0) begin n_fail++; $display("FAIL reset_wport got %0d/%h want 0/0", rf_waddr, rf_wdata); end
    n_checks++; if (fwd_valid !== 1'b0 || fwd_rd !== 5'd0 || fwd_data !== '0) begin n_fail++; $display("FAIL reset_fwd got %b/%0d/%h want 0/0/0", fwd_valid, fwd_rd, fwd_data); end
    n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_mem_err got %b want 0", mem_err); end
    cyc();
    reset = 1'b0; idle_inputs();
    cyc();
  endtask

  task automatic test_alu();
    in_valid = 1'b1; out_sel = 2'b10; alu_out = 32'h1234; pc = 32'h99; rd = 5'd5; rf_le = 1'b1;
    #1;
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL alu_stall got %b want 0", stall_req); end
    cyc();
    idle_inputs();
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL alu_write got %b/%0d/%h want 1/5/1234", rf_we, rf_waddr, rf_wdata); end
    n_checks++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'h1234) begin n_fail++; $display("FAIL alu_fwd got %b/%0d/%h want 1/5/1234", fwd_valid, fwd_rd, fwd_data); end
    cyc();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL alu_pulse got %b want 0", rf_we); end
  endtask

  task automatic test_call();
    in_valid = 1'b1; out_sel = 2'b01; pc = 32'h40; alu_out = 32'h777; rd = 5'd15; rf_le = 1'b1;
    cyc();
    idle_inputs();
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd15 || rf_wdata !== 32'h40) begin n_fail++; $display("FAIL call_write got %b/%0d/%h want 1/15/40", rf_we, rf_waddr, rf_wdata); end
    cyc();
  endtask

  task automatic test_load_wait();
    int stalls = 0, early = 0;
    in_valid = 1'b1; out_sel = 2'b11; rd = 5'd8; rf_le = 1'b1; mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin in_valid = 1'b1; out_sel = 2'b10; rd = 5'd3; alu_out = 32'hDEAD; end
      if (k == 3) begin mem_ready = 1'b1; mem_rdata = 32'hCAFE; end
      #1;
      if (stall_req) stalls++;
      if (rf_we) early++;
      cyc();
      idle_inputs();
    end
    n_checks++; if (stalls != 3) begin n_fail++; $display("FAIL load_stall_cycles got %0d want 3", stalls); end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL load_early_write got %0d want 0", early); end
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'hCAFE) begin n_fail++; $display("FAIL load_write got %b/%0d/%h want 1/8/cafe", rf_we, rf_waddr, rf_wdata); end
    cyc();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL load_pulse got %b want 0", rf_we); end
  endtask

  task automatic test_timeout();
    int stalls = 0, errs = 0, wes = 0;
    in_valid = 1'b1; out_sel = 2'b11; rd = 5'd9; rf_le = 1'b1; mem_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (stall_req) stalls++;
      cyc();
      in_valid = 1'b0;
      if (mem_err) errs++;
      if (rf_we) wes++;
    end
    n_checks++; if (errs != 1) begin n_fail++; $display("FAIL timeout_err_pulses got %0d want 1", errs); end
    n_checks++; if (wes != 0) begin n_fail++; $display("FAIL timeout_writes got %0d want 0", wes); end
    n_checks++; if (stalls != MW + 1) begin n_fail++; $display("FAIL timeout_stall_cycles got %0d want %0d", stalls, MW + 1); end
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL timeout_stall_end got %b want 0", stall_req); end
    in_valid = 1'b1; out_sel = 2'b10; alu_out = 32'h55; rd = 5'd2; rf_le = 1'b1;
    cyc();
    idle_inputs();
    n_checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'h55) begin n_fail++; $display("FAIL timeout_idle_accept got %b/%h want 1/55", rf_we, rf_wdata); end
    cyc();
  endtask

  task automatic test_g0();
    in_valid = 1'b1; out_sel = 2'b10; alu_out = 32'hABC; rd = 5'd0; rf_le = 1'b1;
    cyc();
    idle_inputs();
    n_checks++; if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin n_fail++; $display("FAIL g0_write got %b/%b want 0/0", rf_we, fwd_valid); end
    cyc();
  endtask

  task automatic test_flush();
    in_valid = 1'b1; out_sel = 2'b11; rd = 5'd6; rf_le = 1'b1; mem_ready = 1'b0;
    cyc();
    in_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hBAD; flush = 1'b1;
    #1;
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b want 0", stall_req); end
    cyc();
    idle_inputs();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL flush_write got %b want 0", rf_we); end
    in_valid = 1'b1; out_sel = 2'b11; rd = 5'd9; rf_le = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hBEEF;
    #1;
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL flush_next_stall got %b want 0", stall_req); end
    cyc();
    idle_inputs();
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hBEEF) begin n_fail++; $display("FAIL flush_next_load got %b/%0d/%h want 1/9/beef", rf_we, rf_waddr, rf_wdata); end
    cyc();
  endtask

  // Each instruction runs to completion in a fixed window; outcome follows directly from the rules:
  // flushed -> nothing; load whose data arrives more than MAX_WAIT cycles after issue -> error, no write.
  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [1:0] sel = 2'($urandom_range(0, 3));
      int w = (sel == 2'b11) ? $urandom_range(0, 6) : 0;
      logic le = 1'($urandom_range(0, 3) != 0);
      logic [4:0] r = 5'($urandom_range(0, 31));
      logic fl = ($urandom_range(0, 7) == 0);
      logic [DW-1:0] vpc = $urandom, valu = $urandom, vmem = '0;
      logic timed_out = (sel == 2'b11) && (w > MW);
      int exp_we = (!fl && !timed_out && le && r != 0) ? 1 : 0;
      int exp_err = (!fl && timed_out) ? 1 : 0;
      int exp_stall = fl ? 0 : (sel == 2'b11 ? (w < MW + 1 ? w : MW + 1) : 0);
      int stalls = 0, wes = 0, errs = 0;
      logic [4:0] got_a = '0;
      logic [DW-1:0] got_d = '0, got_f = '0, exp_d;
      for (int k = 0; k < 9; k++) begin
        in_valid = (k == 0); out_sel = sel; rd = r; rf_le = le; pc = vpc; alu_out = valu;
        flush = fl && (k == 0);
        mem_rdata = $urandom;
        mem_ready = (sel == 2'b11) ? (k == w) : 1'($urandom_range(0, 1));
        if (k == w) vmem = mem_rdata;
        #1;
        if (stall_req) stalls++;
        cyc();
        if (rf_we) begin wes++; got_a = rf_waddr; got_d = rf_wdata; got_f = fwd_data; end
        if (mem_err) errs++;
      end
      idle_inputs();
      exp_d = (sel == 2'b10) ? valu : (sel == 2'b11) ? vmem : vpc;
      n_checks++; if (wes != exp_we) begin n_fail++; $display("FAIL rand%0d_writes got %0d want %0d (sel=%0d w=%0d fl=%b)", n, wes, exp_we, sel, w, fl); end
      n_checks++; if (errs != exp_err) begin n_fail++; $display("FAIL rand%0d_mem_err got %0d want %0d", n, errs, exp_err); end
      n_checks++; if (stalls != exp_stall) begin n_fail++; $display("FAIL rand%0d_stalls got %0d want %0d", n, stalls, exp_stall); end
      if (exp_we == 1 && wes == 1) begin
        n_checks++; if (got_a !== r || got_d !== exp_d || got_f !== exp_d) begin n_fail++; $display("FAIL rand%0d_data got %0d/%h/%h want %0d/%h", n, got_a, got_d, got_f, r, exp_d); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_call();
    test_load_wait();
    test_timeout();
    test_g0();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
